// File: rtl/octave_sched.sv
// Octave-change controller: debounced-by-holdoff button edges drive a saturating
// target octave, committed to the divider via req/ack only while no note sounds.

module octave_sched_btn (
   input  logic clk,
   input  logic nrst,
   input  logic raw,
   output logic edge_det
);
   logic [1:0] sync;
   logic       prev;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         sync <= 2'b00;
         prev <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         prev <= sync[1];
      end
   end

   assign edge_det = sync[1] & ~prev;
endmodule

module octave_sched #(
   parameter  int NUM_OCT = 4,
   parameter  int HOLDOFF = 4,
   localparam int OCT_W   = (NUM_OCT > 1) ? $clog2(NUM_OCT) : 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             oct_up,
   input  logic             oct_down,
   input  logic             note_active,
   input  logic             upd_ack,
   output logic             upd_req,
   output logic [OCT_W-1:0] req_oct,
   output logic [OCT_W-1:0] oct_sel,
   output logic             pending
);
   localparam int               HO_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF - 1);
   localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(NUM_OCT - 1);

   typedef enum logic [1:0] {IDLE, WAIT_NOTE, REQ} state_t;

   logic [1:0]       raw;
   logic [1:0]       edges;
   logic             up_edge, dn_edge, accept;
   logic [HO_W-1:0]  holdoff;
   logic [OCT_W-1:0] tgt;
   logic             tgt_diff;
   state_t           state, state_nxt;
   logic             load_req, commit;

   assign raw = {oct_down, oct_up};

   for (genvar b = 0; b < 2; b++) begin : g_btn
      octave_sched_btn u_btn (
         .clk      (clk),
         .nrst     (nrst),
         .raw      (raw[b]),
         .edge_det (edges[b])
      );
   end

   assign up_edge = edges[0];
   assign dn_edge = edges[1];
   // Simultaneous up+down cancels entirely and does not start a holdoff window
   assign accept  = (holdoff == '0) & (up_edge ^ dn_edge);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         holdoff <= '0;
         tgt     <= '0;
      end else begin
         if (accept)
            holdoff <= HO_LOAD;
         else if (holdoff != '0)
            holdoff <= holdoff - 1'b1;

         if (accept) begin
            if (dn_edge && tgt != OCT_MAX)
               tgt <= tgt + 1'b1;
            else if (up_edge && tgt != '0)
               tgt <= tgt - 1'b1;
         end
      end
   end

   assign tgt_diff = (tgt != oct_sel);

   always_comb begin
      state_nxt = state;
      load_req  = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (tgt_diff) begin
               if (note_active) begin
                  state_nxt = WAIT_NOTE;
               end else begin
                  state_nxt = REQ;
                  load_req  = 1'b1;
               end
            end
         end
         WAIT_NOTE: begin
            if (!tgt_diff) begin
               state_nxt = IDLE;
            end else if (!note_active) begin
               state_nxt = REQ;
               load_req  = 1'b1;
            end
         end
         REQ: begin
            // Presses here only move tgt; IDLE picks them up as a fresh request
            if (upd_ack) begin
               state_nxt = IDLE;
               commit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state   <= IDLE;
         upd_req <= 1'b0;
         req_oct <= '0;
         oct_sel <= '0;
      end else begin
         state   <= state_nxt;
         upd_req <= (state_nxt == REQ);
         if (load_req)
            req_oct <= tgt;
         if (commit)
            oct_sel <= req_oct;
      end
   end

   assign pending = tgt_diff | (state != IDLE);
endmodule

// File: tb/tb_octave_sched.sv
// Directed bench for octave_sched: timing of press->request, saturation,
// note gating, holdoff, request hold-off during REQ and mid-handshake reset.

module tb_octave_sched;
   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       oct_up = 1'b0, oct_down = 1'b0, note_active = 1'b0, upd_ack = 1'b0;
   logic       upd_req, pending;
   logic [1:0] req_oct, oct_sel;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   octave_sched #(.NUM_OCT(4), .HOLDOFF(4)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .oct_up      (oct_up),
      .oct_down    (oct_down),
      .note_active (note_active),
      .upd_ack     (upd_ack),
      .upd_req     (upd_req),
      .req_oct     (req_oct),
      .oct_sel     (oct_sel),
      .pending     (pending)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      nrst = 1'b0; oct_up = 1'b0; oct_down = 1'b0; note_active = 1'b0; upd_ack = 1'b0;
      step(2);
      nrst = 1'b1;
   endtask

   task automatic press(input logic up, input logic dn);
      oct_up = up; oct_down = dn;
      step(1);
      oct_up = 1'b0; oct_down = 1'b0;
   endtask

   task automatic ack_pulse;
      upd_ack = 1'b1;
      step(1);
      upd_ack = 1'b0;
   endtask

   task automatic wait_req(input int max, output bit got);
      got = 1'b0;
      for (int k = 0; k < max && !got; k++) begin
         step(1);
         if (upd_req === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      step(2);
      checks++;
      if ({upd_req, req_oct, oct_sel, pending} !== 6'b0) begin
         errors++;
         $display("FAIL reset: req=%b req_oct=%0d oct_sel=%0d pending=%b, expected all 0",
                  upd_req, req_oct, oct_sel, pending);
      end
      nrst = 1'b1;
      step(1);
   endtask

   task automatic test_single_press;
      do_reset;
      press(1'b0, 1'b1);
      step(2);
      checks++;
      if (pending !== 1'b1 || upd_req !== 1'b0) begin
         errors++;
         $display("FAIL single_pre_req: pending=%b upd_req=%b, expected 1/0", pending, upd_req);
      end
      step(1);
      checks++;
      if (upd_req !== 1'b1 || req_oct !== 2'd1) begin
         errors++;
         $display("FAIL single_req: upd_req=%b req_oct=%0d, expected 1/1", upd_req, req_oct);
      end
      step(1);
      checks++;
      if (upd_req !== 1'b1 || oct_sel !== 2'd0) begin
         errors++;
         $display("FAIL single_req_hold: upd_req=%b oct_sel=%0d, expected 1/0", upd_req, oct_sel);
      end
      ack_pulse;
      checks++;
      if (oct_sel !== 2'd1 || upd_req !== 1'b0 || pending !== 1'b0) begin
         errors++;
         $display("FAIL single_ack: oct_sel=%0d upd_req=%b pending=%b, expected 1/0/0",
                  oct_sel, upd_req, pending);
      end
   endtask

   task automatic test_saturation;
      bit         got;
      logic [1:0] exp;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         press(1'b0, 1'b1);
         wait_req(8, got);
         exp = (i < 3) ? 2'(i + 1) : 2'd3;
         checks++;
         if (got !== (i < 3)) begin
            errors++;
            $display("FAIL sat_down_req%0d: request seen=%b, expected %b", i, got, (i < 3));
         end
         if (got) begin
            checks++;
            if (req_oct !== exp) begin
               errors++;
               $display("FAIL sat_down_val%0d: req_oct=%0d, expected %0d", i, req_oct, exp);
            end
            ack_pulse;
         end
         checks++;
         if (oct_sel !== exp || pending !== 1'b0) begin
            errors++;
            $display("FAIL sat_down_sel%0d: oct_sel=%0d pending=%b, expected %0d/0",
                     i, oct_sel, pending, exp);
         end
      end
      for (int j = 0; j < 5; j++) begin
         press(1'b1, 1'b0);
         wait_req(8, got);
         exp = (j < 3) ? 2'(2 - j) : 2'd0;
         checks++;
         if (got !== (j < 3)) begin
            errors++;
            $display("FAIL sat_up_req%0d: request seen=%b, expected %b", j, got, (j < 3));
         end
         if (got) ack_pulse;
         checks++;
         if (oct_sel !== exp || pending !== 1'b0) begin
            errors++;
            $display("FAIL sat_up_sel%0d: oct_sel=%0d pending=%b, expected %0d/0",
                     j, oct_sel, pending, exp);
         end
      end
   endtask

   task automatic test_wait_note;
      bit seen;
      do_reset;
      note_active = 1'b1;
      press(1'b0, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (upd_req !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || pending !== 1'b1) begin
         errors++;
         $display("FAIL note_hold: req seen=%b pending=%b, expected 0/1", seen, pending);
      end
      note_active = 1'b0;
      step(1);
      checks++;
      if (upd_req !== 1'b1 || req_oct !== 2'd1) begin
         errors++;
         $display("FAIL note_release: upd_req=%b req_oct=%0d, expected 1/1", upd_req, req_oct);
      end
      ack_pulse;
      checks++;
      if (oct_sel !== 2'd1) begin
         errors++;
         $display("FAIL note_ack: oct_sel=%0d, expected 1", oct_sel);
      end
   endtask

   task automatic test_holdoff;
      bit got;
      do_reset;
      // two rising edges two cycles apart; second lands inside holdoff
      oct_down = 1'b1; step(1);
      oct_down = 1'b0; step(1);
      oct_down = 1'b1; step(1);
      oct_down = 1'b0;
      wait_req(6, got);
      checks++;
      if (got !== 1'b1 || req_oct !== 2'd1) begin
         errors++;
         $display("FAIL holdoff_req: seen=%b req_oct=%0d, expected 1/1", got, req_oct);
      end
      ack_pulse;
      step(3);
      checks++;
      if (oct_sel !== 2'd1 || pending !== 1'b0 || upd_req !== 1'b0) begin
         errors++;
         $display("FAIL holdoff_drop: oct_sel=%0d pending=%b upd_req=%b, expected 1/0/0",
                  oct_sel, pending, upd_req);
      end
      step(6);
      press(1'b1, 1'b1);
      step(1);
      oct_down = 1'b1; step(1);
      oct_down = 1'b0;
      checks++;
      if (pending !== 1'b0) begin
         errors++;
         $display("FAIL simult_discard: pending=%b, expected 0", pending);
      end
      // simultaneous press must not start holdoff, so this down is accepted
      wait_req(6, got);
      checks++;
      if (got !== 1'b1 || req_oct !== 2'd2) begin
         errors++;
         $display("FAIL simult_no_holdoff: seen=%b req_oct=%0d, expected 1/2", got, req_oct);
      end
      if (got) ack_pulse;
      checks++;
      if (oct_sel !== 2'd2) begin
         errors++;
         $display("FAIL simult_ack: oct_sel=%0d, expected 2", oct_sel);
      end
   endtask

   task automatic test_req_hold;
      bit got;
      do_reset;
      press(1'b0, 1'b1);
      wait_req(6, got);
      checks++;
      if (got !== 1'b1 || req_oct !== 2'd1) begin
         errors++;
         $display("FAIL hold_first: seen=%b req_oct=%0d, expected 1/1", got, req_oct);
      end
      step(5);
      press(1'b0, 1'b1);
      step(6);
      press(1'b0, 1'b1);
      step(6);
      checks++;
      if (upd_req !== 1'b1 || req_oct !== 2'd1 || oct_sel !== 2'd0) begin
         errors++;
         $display("FAIL hold_stable: upd_req=%b req_oct=%0d oct_sel=%0d, expected 1/1/0",
                  upd_req, req_oct, oct_sel);
      end
      ack_pulse;
      checks++;
      if (oct_sel !== 2'd1) begin
         errors++;
         $display("FAIL hold_ack1: oct_sel=%0d, expected 1", oct_sel);
      end
      wait_req(6, got);
      checks++;
      if (got !== 1'b1 || req_oct !== 2'd3) begin
         errors++;
         $display("FAIL hold_second: seen=%b req_oct=%0d, expected 1/3", got, req_oct);
      end
      if (got) ack_pulse;
      checks++;
      if (oct_sel !== 2'd3 || pending !== 1'b0) begin
         errors++;
         $display("FAIL hold_ack2: oct_sel=%0d pending=%b, expected 3/0", oct_sel, pending);
      end
   endtask

   task automatic test_reset_mid;
      bit got;
      do_reset;
      press(1'b0, 1'b1);
      wait_req(6, got);
      if (got) ack_pulse;
      step(6);
      press(1'b0, 1'b1);
      wait_req(6, got);
      checks++;
      if (got !== 1'b1 || oct_sel !== 2'd1) begin
         errors++;
         $display("FAIL mid_setup: seen=%b oct_sel=%0d, expected 1/1", got, oct_sel);
      end
      nrst = 1'b0;
      step(1);
      checks++;
      if ({upd_req, req_oct, oct_sel, pending} !== 6'b0) begin
         errors++;
         $display("FAIL mid_reset: req=%b req_oct=%0d oct_sel=%0d pending=%b, expected all 0",
                  upd_req, req_oct, oct_sel, pending);
      end
      nrst = 1'b1;
      step(1);
      ack_pulse;
      step(2);
      checks++;
      if (oct_sel !== 2'd0 || upd_req !== 1'b0 || pending !== 1'b0) begin
         errors++;
         $display("FAIL mid_stray_ack: oct_sel=%0d upd_req=%b pending=%b, expected 0/0/0",
                  oct_sel, upd_req, pending);
      end
   endtask

   initial begin
      step(1);
      test_reset;
      test_single_press;
      test_saturation;
      test_wait_note;
      test_holdoff;
      test_req_hold;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
